// File: rtl/dotn_accum.sv
// Pipelined LANES-wide signed dot product with optional multi-beat group accumulation.
// Groups are delimited by ifirst/ilast. Each completed group produces one result, with a sticky overflow flag.
module dotn_accum #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 32,
  parameter int LANES  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*IWIDTH-1:0]   vec0,
  input  logic [LANES*IWIDTH-1:0]   vec1,
  input  logic                      ivalid,
  input  logic                      ifirst,
  input  logic                      ilast,
  output logic [OWIDTH-1:0]         result,
  output logic                      ovalid,
  output logic                      oovf
);

  localparam int T  = $clog2(LANES);
  localparam int PW = 2*IWIDTH + T;   // full-precision width of the tree root
  localparam int NN = 2*LANES - 1;    // heap-ordered tree: node 0 root, leaves LANES-1..NN-1

  logic [LANES*IWIDTH-1:0] a0, b0;
  logic [T+1:0]            vld_sr, fst_sr, lst_sr;
  logic signed [PW-1:0]    node [NN];

  logic signed [OWIDTH-1:0] acc, part, acc_nxt;
  logic                     grp_open, ovf_sticky;
  logic                     start, add_ovf, ovf_nxt, fin_vld;

  // Operand capture, products and adder tree. Flags ride a shift register aligned with the tree root.
  always_ff @(posedge clk) begin
    if (rst) begin
      a0     <= '0;
      b0     <= '0;
      vld_sr <= '0;
      fst_sr <= '0;
      lst_sr <= '0;
      for (int i = 0; i < NN; i++) node[i] <= '0;
    end else begin
      a0     <= vec0;
      b0     <= vec1;
      vld_sr <= {vld_sr[T:0], ivalid};
      fst_sr <= {fst_sr[T:0], ifirst};
      lst_sr <= {lst_sr[T:0], ilast};
      for (int k = 0; k < LANES; k++)
        node[LANES-1+k] <= PW'($signed(a0[k*IWIDTH +: IWIDTH])) *
                           PW'($signed(b0[k*IWIDTH +: IWIDTH]));
      for (int i = 0; i < LANES-1; i++)
        node[i] <= node[2*i+1] + node[2*i+2];
    end
  end

  // A beat with no open group counts as an implicit first beat.
  always_comb begin
    fin_vld = vld_sr[T+1];
    part    = OWIDTH'(node[0]);
    start   = fst_sr[T+1] || !grp_open;
    acc_nxt = start ? part : acc + part;
    add_ovf = !start && (acc[OWIDTH-1] == part[OWIDTH-1]) &&
              (acc_nxt[OWIDTH-1] != acc[OWIDTH-1]);
    ovf_nxt = (!start && ovf_sticky) || add_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      grp_open   <= 1'b0;
      ovf_sticky <= 1'b0;
      result     <= '0;
      ovalid     <= 1'b0;
      oovf       <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      if (fin_vld) begin
        acc        <= acc_nxt;
        ovf_sticky <= ovf_nxt;
        grp_open   <= !lst_sr[T+1];
        if (lst_sr[T+1]) begin
          result <= acc_nxt;
          oovf   <= ovf_nxt;
          ovalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dotn_accum.sv
// Directed bench for dotn_accum. It runs an 8-lane instance with OWIDTH=32 and one with OWIDTH=20.
// Both instances share the same stimulus, and the output timing is checked against the drive cycle.
module tb_dotn_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] vec0, vec1;
  logic        ivalid, ifirst, ilast;
  logic [31:0] result32;
  logic        ovalid32, oovf32;
  logic [19:0] result20;
  logic        ovalid20, oovf20;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [31:0] got_q[$];
  logic        got_ovf_q[$];
  int          got_cyc_q[$];
  logic [31:0] got20_q[$];
  logic        got20_ovf_q[$];
  logic [31:0] exp_q[$];
  logic        exp_ovf_q[$];
  int          exp_cyc_q[$];

  always #5 clk = ~clk;

  dotn_accum #(.IWIDTH(8), .OWIDTH(32), .LANES(8)) u_dut32 (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid),
    .ifirst(ifirst), .ilast(ilast), .result(result32), .ovalid(ovalid32), .oovf(oovf32)
  );

  dotn_accum #(.IWIDTH(8), .OWIDTH(20), .LANES(8)) u_dut20 (
    .clk(clk), .rst(rst), .vec0(vec0), .vec1(vec1), .ivalid(ivalid),
    .ifirst(ifirst), .ilast(ilast), .result(result20), .ovalid(ovalid20), .oovf(oovf20)
  );

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (ovalid32) begin
      got_q.push_back(result32);
      got_ovf_q.push_back(oovf32);
      got_cyc_q.push_back(cyc);
    end
    if (ovalid20) begin
      got20_q.push_back({{12{result20[19]}}, result20});
      got20_ovf_q.push_back(oovf20);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [63:0] splat(input logic [7:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [63:0] ramp();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(i + 1);
    return r;
  endfunction

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic f, input logic l,
                      output int at);
    @(negedge clk);
    rst = 1'b0; vec0 = a; vec1 = b; ivalid = 1'b1; ifirst = f; ilast = l;
    at = cyc;
  endtask

  // Bubbles carry random data and flags to show that invalid cycles are ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rst = 1'b0; ivalid = 1'b0;
      ifirst = 1'($urandom); ilast = 1'($urandom);
      vec0 = {$urandom, $urandom}; vec1 = {$urandom, $urandom};
    end
  endtask

  task automatic expect_out(input logic [31:0] r, input logic o, input int c);
    exp_q.push_back(r);
    exp_ovf_q.push_back(o);
    exp_cyc_q.push_back(c);
  endtask

  task automatic score(input string tag);
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, " result"}, got_q.pop_front(), exp_q.pop_front());
      check({tag, " oovf"}, 32'(got_ovf_q.pop_front()), 32'(exp_ovf_q.pop_front()));
      check({tag, " cycle"}, 32'(got_cyc_q.pop_front()), 32'(exp_cyc_q.pop_front()));
    end
    got_q.delete(); got_ovf_q.delete(); got_cyc_q.delete();
    exp_q.delete(); exp_ovf_q.delete(); exp_cyc_q.delete();
  endtask

  initial begin
    int t0, t1, t2;
    rst = 1'b1; ivalid = 1'b0; ifirst = 1'b0; ilast = 1'b0; vec0 = '0; vec1 = '0;
    repeat (3) @(negedge clk);
    check("reset ovalid", 32'(ovalid32), 32'd0);
    check("reset oovf", 32'(oovf32), 32'd0);
    check("reset result", result32, 32'd0);
    check("reset ovalid20", 32'(ovalid20), 32'd0);
    check("reset result20", 32'(result20), 32'd0);
    rst = 1'b0;
    idle(2);

    // 1: single beat; ones times ramp = 36
    beat(splat(8'd1), ramp(), 1'b1, 1'b1, t0);
    expect_out(32'd36, 1'b0, t0 + 6);
    idle(10);
    score("t1 single");

    // 2: extremes, back to back
    beat(splat(8'h80), splat(8'h80), 1'b1, 1'b1, t0);
    beat(splat(8'h80), splat(8'h7f), 1'b1, 1'b1, t1);
    expect_out(32'd131072, 1'b0, t0 + 6);
    expect_out(-32'sd130048, 1'b0, t1 + 6);
    idle(10);
    score("t2 extremes");

    // 3: three beats of 48 with bubbles of 0 and 2 between them
    beat(splat(8'd2), splat(8'd3), 1'b1, 1'b0, t0);
    beat(splat(8'd2), splat(8'd3), 1'b0, 1'b0, t0);
    idle(2);
    beat(splat(8'd2), splat(8'd3), 1'b0, 1'b1, t0);
    expect_out(32'd144, 1'b0, t0 + 6);
    idle(10);
    score("t3 group");

    // 4: group A then group B starting the very next cycle
    beat(splat(8'd1), ramp(), 1'b1, 1'b1, t0);
    beat(splat(8'd1), splat(8'd1), 1'b1, 1'b0, t1);
    beat(splat(8'd1), splat(8'd1), 1'b0, 1'b1, t2);
    expect_out(32'd36, 1'b0, t0 + 6);
    expect_out(32'd16, 1'b0, t2 + 6);
    idle(10);
    score("t4 adjacent");

    // 4b: ifirst inside an open group discards the old partial sum (16, not 24)
    beat(splat(8'd1), splat(8'd1), 1'b1, 1'b0, t0);
    beat(splat(8'd1), splat(8'd1), 1'b1, 1'b0, t0);
    beat(splat(8'd1), splat(8'd1), 1'b0, 1'b1, t0);
    expect_out(32'd16, 1'b0, t0 + 6);
    idle(10);
    score("t4 restart");

    // 5: 5 x 129032 wraps the 20-bit accumulator; the 32-bit one does not wrap
    got20_q.delete(); got20_ovf_q.delete();
    beat(splat(8'd127), splat(8'd127), 1'b1, 1'b0, t0);
    repeat (3) beat(splat(8'd127), splat(8'd127), 1'b0, 1'b0, t0);
    beat(splat(8'd127), splat(8'd127), 1'b0, 1'b1, t0);
    expect_out(32'd645160, 1'b0, t0 + 6);
    idle(10);
    score("t5 wide");
    check("t5 narrow count", 32'(got20_q.size()), 32'd1);
    if (got20_q.size() > 0) begin
      check("t5 narrow result", got20_q.pop_front(), -32'sd403416);
      check("t5 narrow oovf", 32'(got20_ovf_q.pop_front()), 32'd1);
    end
    beat(splat(8'd1), splat(8'd1), 1'b1, 1'b1, t0);
    expect_out(32'd8, 1'b0, t0 + 6);
    idle(10);
    score("t5 next");
    check("t5 narrow next count", 32'(got20_q.size()), 32'd1);
    if (got20_q.size() > 0) begin
      check("t5 narrow next result", got20_q.pop_front(), 32'd8);
      check("t5 narrow next oovf", 32'(got20_ovf_q.pop_front()), 32'd0);
    end

    // 6: reset during beat 2 drops everything in flight
    beat(splat(8'd1), ramp(), 1'b1, 1'b0, t0);
    beat(splat(8'd1), ramp(), 1'b0, 1'b0, t0);
    rst = 1'b1;
    idle(12);
    score("t6 dropped");
    beat(splat(8'd1), ramp(), 1'b1, 1'b1, t0);
    expect_out(32'd36, 1'b0, t0 + 6);
    idle(10);
    score("t6 after");

    // ilast with no open group is an implicit single-beat group
    beat(splat(8'd2), ramp(), 1'b0, 1'b1, t0);
    expect_out(32'd72, 1'b0, t0 + 6);
    idle(10);
    score("implicit first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
